// File: rtl/iua_usb_pkg.sv
// Shared constants, FSM state type and NRZI helpers for the full-speed USB transmitter.
package iua_usb_pkg;

  localparam logic [1:0] LINE_J    = 2'b10;  // {dp, dn}
  localparam logic [1:0] LINE_K    = 2'b01;
  localparam logic [1:0] LINE_SE0  = 2'b00;
  localparam logic [7:0] SYNC_PAT  = 8'h80;
  localparam logic [2:0] STUFF_LEN = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J,
    ST_GAP
  } state_t;

  // NRZI: a 0 swaps J<->K, a 1 holds the line.
  function automatic logic [1:0] nrzi(input logic [1:0] l, input logic b);
    return b ? l : ~l;
  endfunction

  function automatic logic [2:0] next_ones(input logic [2:0] ones, input logic b);
    return b ? ones + 3'd1 : 3'd0;
  endfunction

endpackage

// File: rtl/iua_nco.sv
// Phase accumulator producing the bit-rate strobe from the capture clock.
module iua_nco #(
  parameter int PHASE_INC = 5108
) (
  input  logic clk_samp,
  input  logic rst,
  output logic strobe
);

  logic [15:0] acc;
  logic [16:0] sum;

  assign sum    = {1'b0, acc} + 17'(PHASE_INC);
  assign strobe = sum[16];

  always_ff @(posedge clk_samp) begin
    if (rst) acc <= '0;
    else     acc <= sum[15:0];
  end

endmodule

// File: rtl/iua_usb_tx.sv
// Full-speed USB packet serializer: SYNC, NRZI with bit stuffing, EOP and inter-packet gap.
module iua_usb_tx
  import iua_usb_pkg::*;
#(
  parameter int PHASE_INC = 5108,
  parameter int IPG_BITS  = 4
) (
  input  logic       clk_samp,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       usb_dp,
  output logic       usb_dn,
  output logic       busy,
  output logic       underrun
);

  logic       strobe;
  state_t     state;
  logic [7:0] cnt;
  logic [7:0] shreg;
  logic       last_q;
  logic [2:0] ones;
  logic [1:0] line;
  logic       load_due;

  iua_nco #(.PHASE_INC(PHASE_INC)) u_nco (
    .clk_samp(clk_samp),
    .rst     (rst),
    .strobe  (strobe)
  );

  assign usb_dp = line[1];
  assign usb_dn = line[0];

  // A byte is due after SYNC and after every 8th data bit, unless a stuff bit must go first.
  assign load_due = (state == ST_SYNC && cnt == 8'd8) ||
                    (state == ST_DATA && ones != STUFF_LEN && cnt == 8'd8 && !last_q);

  // Registered line/state describe the bit time that starts after each strobe.
  always_ff @(posedge clk_samp) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shreg    <= '0;
      last_q   <= 1'b0;
      ones     <= '0;
      line     <= LINE_J;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      in_ready <= 1'b0;
      underrun <= 1'b0;
      if (strobe) begin
        if (load_due) begin
          cnt <= 8'd1;
          if (in_valid) begin
            in_ready <= 1'b1;
            shreg    <= {1'b0, in_data[7:1]};
            last_q   <= in_last;
            line     <= nrzi(line, in_data[0]);
            ones     <= next_ones(ones, in_data[0]);
            state    <= ST_DATA;
          end else begin
            underrun <= 1'b1;
            line     <= LINE_SE0;
            state    <= ST_EOP_SE0;
          end
        end else begin
          case (state)
            ST_IDLE: begin
              if (in_valid) begin
                line  <= nrzi(line, SYNC_PAT[0]);
                ones  <= next_ones(ones, SYNC_PAT[0]);
                cnt   <= 8'd1;
                busy  <= 1'b1;
                state <= ST_SYNC;
              end
            end
            ST_SYNC: begin
              line <= nrzi(line, SYNC_PAT[cnt[2:0]]);
              ones <= next_ones(ones, SYNC_PAT[cnt[2:0]]);
              cnt  <= cnt + 8'd1;
            end
            ST_DATA: begin
              if (ones == STUFF_LEN) begin
                line <= nrzi(line, 1'b0);
                ones <= 3'd0;
              end else if (cnt == 8'd8) begin
                line  <= LINE_SE0;
                cnt   <= 8'd1;
                state <= ST_EOP_SE0;
              end else begin
                line  <= nrzi(line, shreg[0]);
                ones  <= next_ones(ones, shreg[0]);
                shreg <= {1'b0, shreg[7:1]};
                cnt   <= cnt + 8'd1;
              end
            end
            ST_EOP_SE0: begin
              if (cnt < 8'd2) begin
                cnt <= cnt + 8'd1;
              end else begin
                line  <= LINE_J;
                state <= ST_EOP_J;
              end
            end
            ST_EOP_J: begin
              if (IPG_BITS == 0) begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end else begin
                cnt   <= 8'd1;
                state <= ST_GAP;
              end
            end
            ST_GAP: begin
              if (cnt < 8'(IPG_BITS)) begin
                cnt <= cnt + 8'd1;
              end else begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end
            default: begin
              line  <= LINE_J;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_iua_usb_tx.sv
// Scoreboard bench: a USB bit-level model predicts line symbols per packet; a monitor compares and decodes.
module tb_iua_usb_tx;

  localparam int         INC_FAST = 65536;
  localparam int         INC_SLOW = 5108;
  localparam int         IPG      = 4;
  localparam logic [1:0] SJ       = 2'b10;
  localparam logic [1:0] SK       = 2'b01;
  localparam logic [1:0] SSE0     = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data  [2];
  logic       in_last  [2];
  logic       in_valid [2];
  logic       in_ready [2];
  logic       dp       [2];
  logic       dn       [2];
  logic       busy     [2];
  logic       underrun [2];
  logic       dut_stb  [2];

  always #5 clk = ~clk;

  iua_usb_tx #(.PHASE_INC(INC_FAST), .IPG_BITS(IPG)) u_fast (
    .clk_samp(clk), .rst(rst), .in_data(in_data[0]), .in_last(in_last[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .usb_dp(dp[0]), .usb_dn(dn[0]),
    .busy(busy[0]), .underrun(underrun[0]));

  iua_usb_tx #(.PHASE_INC(INC_SLOW), .IPG_BITS(IPG)) u_slow (
    .clk_samp(clk), .rst(rst), .in_data(in_data[1]), .in_last(in_last[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .usb_dp(dp[1]), .usb_dn(dn[1]),
    .busy(busy[1]), .underrun(underrun[1]));

  assign dut_stb[0] = u_fast.u_nco.strobe;
  assign dut_stb[1] = u_slow.u_nco.strobe;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic longint inc_of(input int k);
    return (k == 0) ? longint'(INC_FAST) : longint'(INC_SLOW);
  endfunction

  // Reference bit clock: fractional phase in bit units; wrap marks the edge that starts a new bit time.
  longint ph [2];
  bit     stb_edge [2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ph[k]       <= 0;
        stb_edge[k] <= 1'b0;
      end else begin
        stb_edge[k] <= (ph[k] + inc_of(k)) >= 65536;
        ph[k]       <= (ph[k] + inc_of(k)) % 65536;
      end
    end
  end

  // Expected traffic, one entry set per packet.
  logic [1:0] exp_q   [2][$];
  int         len_q   [2][$];
  logic [7:0] byte_q  [2][$];
  int         nbyte_q [2][$];
  logic [1:0] got     [2][$];

  // USB framing from first principles: SYNC+data bits, stuff after six 1s, NRZI from J, EOP, gap.
  task automatic exp_push(input int k, input logic [7:0] b[$]);
    bit         bits[$];
    logic [1:0] lvl;
    logic [7:0] sp;
    int         ones, n;
    sp = 8'h80;
    for (int i = 0; i < 8; i++) bits.push_back(sp[i]);
    foreach (b[j]) for (int i = 0; i < 8; i++) bits.push_back(b[j][i]);
    lvl = SJ; ones = 0; n = 0;
    foreach (bits[i]) begin
      if (!bits[i]) lvl = (lvl == SJ) ? SK : SJ;
      exp_q[k].push_back(lvl); n++;
      ones = bits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        lvl = (lvl == SJ) ? SK : SJ;
        exp_q[k].push_back(lvl); n++;
        ones = 0;
      end
    end
    exp_q[k].push_back(SSE0); exp_q[k].push_back(SSE0); exp_q[k].push_back(SJ);
    n += 3;
    for (int i = 0; i < IPG; i++) begin exp_q[k].push_back(SJ); n++; end
    len_q[k].push_back(n);
    nbyte_q[k].push_back(b.size());
    foreach (b[j]) byte_q[k].push_back(b[j]);
  endtask

  // Recover bytes from line symbols: NRZI decode, drop stuffed bits, discard SYNC.
  function automatic void decode(input logic [1:0] s[$], output logic [7:0] b[$]);
    logic [1:0] lvl;
    logic [7:0] cur;
    int         ones, nbit;
    bit         skip, bt;
    lvl = SJ; cur = '0; ones = 0; nbit = 0; skip = 0; b.delete();
    for (int i = 0; i < s.size(); i++) begin
      if (s[i] == SSE0) break;
      bt  = (s[i] == lvl);
      lvl = s[i];
      if (skip) begin skip = 0; ones = 0; continue; end
      ones = bt ? ones + 1 : 0;
      if (ones == 6) skip = 1;
      if (nbit >= 8) begin
        cur = {bt, cur[7:1]};
        if (((nbit - 8) % 8) == 7) b.push_back(cur);
      end
      nbit++;
    end
  endfunction

  task automatic finish_pkt(input int k);
    int         n, nb, bad, first;
    logic [1:0] e, g0, e0;
    logic [7:0] dec[$];
    logic [7:0] eb;
    n = len_q[k].pop_front();
    bad = 0; first = -1; g0 = '0; e0 = '0;
    for (int i = 0; i < n; i++) begin
      e = exp_q[k].pop_front();
      if (got[k][i] !== e) begin
        bad++;
        if (first < 0) begin first = i; g0 = got[k][i]; e0 = e; end
      end
    end
    if (bad != 0)
      $display("  dut%0d symbol %0d: line %b, expected %b", k, first, g0, e0);
    check($sformatf("line_seq_dut%0d", k), bad, 0);
    decode(got[k], dec);
    nb = nbyte_q[k].pop_front();
    bad = (dec.size() == nb) ? 0 : 1;
    for (int i = 0; i < nb; i++) begin
      eb = byte_q[k].pop_front();
      if (i >= dec.size() || dec[i] !== eb) bad++;
    end
    check($sformatf("decode_dut%0d", k), bad, 0);
  endtask

  int         ir_cnt [2], ur_cnt [2], hold_err [2], nco_err [2];
  bit         cap [2], eop [2];
  logic [1:0] mon_s;
  bit         iv_en   = 1'b0;
  longint     iv_last = -1;
  longint     iv_n    = 0;
  longint     iv_sum  = 0;
  longint     cyc     = 0;
  int         iv_min  = 1000;
  int         iv_max  = 0;

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cap[k] = 1'b0;
        eop[k] = 1'b0;
      end else begin
        if (dut_stb[k] !== ((ph[k] + inc_of(k)) >= 65536)) nco_err[k]++;
        if (in_ready[k]) begin
          ir_cnt[k]++;
          if (eop[k]) hold_err[k]++;
        end
        if (underrun[k]) ur_cnt[k]++;
        if (stb_edge[k]) begin
          mon_s = {dp[k], dn[k]};
          if (mon_s == SSE0) eop[k] = 1'b1;
          else if (mon_s == SK) eop[k] = 1'b0;
          if (!cap[k] && len_q[k].size() > 0 && mon_s != SJ) begin
            cap[k] = 1'b1;
            got[k].delete();
          end
          if (cap[k]) begin
            got[k].push_back(mon_s);
            if (got[k].size() == len_q[k][0]) begin
              finish_pkt(k);
              cap[k] = 1'b0;
            end
          end
        end
      end
    end
    if (iv_en && dut_stb[1]) begin
      if (iv_last >= 0) begin
        iv_n++;
        iv_sum += cyc - iv_last;
        if (int'(cyc - iv_last) < iv_min) iv_min = int'(cyc - iv_last);
        if (int'(cyc - iv_last) > iv_max) iv_max = int'(cyc - iv_last);
      end
      iv_last = cyc;
    end
  end

  task automatic send_pkt(input int k, input logic [7:0] b[$], input bit keep, input bit mark_last);
    bit got_r;
    for (int i = 0; i < b.size(); i++) begin
      got_r       = 1'b0;
      in_data[k]  = b[i];
      in_last[k]  = mark_last && (i == b.size() - 1);
      in_valid[k] = 1'b1;
      for (int c = 0; c < 4000 && !got_r; c++) begin
        @(negedge clk);
        got_r = in_ready[k];
      end
      if (!got_r) begin
        check($sformatf("ready_timeout_dut%0d", k), 0, 1);
        in_valid[k] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (!keep) in_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20000 && !ok; c++) begin
      @(negedge clk);
      ok = (len_q[k].size() == 0) && !cap[k] && !busy[k];
    end
    check({name, "_done"}, ok, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, want finish before 90000 cycles");
    $fatal(1);
  end

  logic [7:0] pk[$], pk2[$];
  int         ir0, ur0, he0;
  bit         ok;

  initial begin
    for (int k = 0; k < 2; k++) begin
      in_data[k] = '0; in_last[k] = 1'b0; in_valid[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_dp_dut%0d", k), dp[k], 1);
      check($sformatf("rst_dn_dut%0d", k), dn[k], 0);
      check($sformatf("rst_ready_dut%0d", k), in_ready[k], 0);
      check($sformatf("rst_busy_dut%0d", k), busy[k], 0);
      check($sformatf("rst_underrun_dut%0d", k), underrun[k], 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk); #1;

    // Single byte 0xA5
    ir0 = ir_cnt[0]; ur0 = ur_cnt[0];
    pk.delete(); pk.push_back(8'hA5);
    exp_push(0, pk); send_pkt(0, pk, 0, 1); wait_idle(0, "a5");
    check("a5_ready_pulses", ir_cnt[0] - ir0, 1);
    check("a5_underrun", ur_cnt[0] - ur0, 0);

    // All ones: two stuff bits inside the packet
    ir0 = ir_cnt[0];
    pk.delete(); pk.push_back(8'hFF); pk.push_back(8'hFF);
    exp_push(0, pk); send_pkt(0, pk, 0, 1); wait_idle(0, "ff_ff");
    check("ff_ready_pulses", ir_cnt[0] - ir0, 2);

    // Starvation after one non-final byte
    ir0 = ir_cnt[0]; ur0 = ur_cnt[0];
    pk.delete(); pk.push_back(8'h00);
    exp_push(0, pk); send_pkt(0, pk, 0, 0); wait_idle(0, "underrun");
    check("underrun_pulses", ur_cnt[0] - ur0, 1);
    check("underrun_ready_pulses", ir_cnt[0] - ir0, 1);
    check("underrun_busy_low", busy[0], 0);

    // Reset during the third data bit
    in_data[0] = 8'h3C; in_last[0] = 1'b1; in_valid[0] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin @(negedge clk); ok = in_ready[0]; end
    check("abort_first_load", ok, 1);
    in_valid[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_line_j", {dp[0], dn[0]}, SJ);
    check("abort_busy", busy[0], 0);
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    pk.delete(); pk.push_back(8'h5A);
    exp_push(0, pk); send_pkt(0, pk, 0, 1); wait_idle(0, "after_abort");

    // Back-to-back with in_valid held high through EOP and gap
    ir0 = ir_cnt[0]; he0 = hold_err[0];
    pk.delete(); pk2.delete();
    for (int i = 0; i < 2; i++) pk.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 3; i++) pk2.push_back(8'($urandom_range(0, 255)));
    exp_push(0, pk); exp_push(0, pk2);
    send_pkt(0, pk, 1, 1); send_pkt(0, pk2, 0, 1); wait_idle(0, "b2b");
    check("b2b_ready_in_eop_gap", hold_err[0] - he0, 0);
    check("b2b_ready_pulses", ir_cnt[0] - ir0, 5);

    // Short random packets
    for (int p = 0; p < 3; p++) begin
      pk.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) pk.push_back(8'($urandom_range(0, 255)));
      exp_push(0, pk); send_pkt(0, pk, 0, 1); wait_idle(0, "rand_fast");
    end

    // 100-byte packet at the default rate
    ir0 = ir_cnt[1];
    pk.delete();
    for (int i = 0; i < 100; i++) pk.push_back(8'($urandom_range(0, 255)));
    iv_en = 1'b1;
    exp_push(1, pk); send_pkt(1, pk, 0, 1); wait_idle(1, "long_slow");
    iv_en = 1'b0;
    check("slow_ready_pulses", ir_cnt[1] - ir0, 100);
    check("strobe_interval_min", iv_min, 12);
    check("strobe_interval_max", iv_max, 13);
    ok = ((iv_sum * INC_SLOW - iv_n * 65536) * 1000 <= iv_n * 65536) &&
         ((iv_n * 65536 - iv_sum * INC_SLOW) * 1000 <= iv_n * 65536) && (iv_n > 500);
    check("strobe_mean", ok, 1);
    check("nco_strobe_fast", nco_err[0], 0);
    check("nco_strobe_slow", nco_err[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
